// File: rtl/alu_logic_sequencer.sv
// alu_logic_sequencer: gathers operand beats for the 8-bit logic unit, drives its A/B/S registers,
// and captures its combinational result onto a valid/ready result port with a zero flag and op counter.
module alu_logic_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, LOAD_B, EXEC, RESP} state_t;
    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_s;
    logic [WIDTH-1:0]  r_res;
    logic              r_zero;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_in_fire;
    logic              w_res_fire;
    assign w_in_fire  = in_valid && in_ready;
    assign w_res_fire = res_valid && res_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    // NOT needs only operand A, so it skips LOAD_B
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_in_fire ? ((in_op == 2'b11) ? EXEC : LOAD_B) : IDLE;
            LOAD_B:  w_next = w_in_fire ? EXEC : LOAD_B;
            EXEC:    w_next = RESP;
            RESP:    w_next = w_res_fire ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = (r_state == IDLE) || (r_state == LOAD_B);
        res_valid = (r_state == RESP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= '0;
            r_res  <= '0;
            r_zero <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_in_fire && r_state == IDLE) begin
                r_a <= in_data;
                r_s <= in_op;
                if (in_op == 2'b11)
                    r_b <= '0;
            end
            if (w_in_fire && r_state == LOAD_B)
                r_b <= in_data;
            if (r_state == EXEC) begin
                r_res  <= alu_out;
                r_zero <= (alu_out == '0);
            end
            if (w_res_fire)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_s    = r_s;
    assign res_data = r_res;
    assign res_zero = r_zero;
    assign op_count = r_cnt;
endmodule
